// File: rtl/debug_probe_mux_pkg.sv
// debug_probe_pkg: shared definitions for the debug probe multiplexer.
//   mode_e        - output formatting mode of every probe channel
//   state_e       - freeze controller states
//   MODE_W        - width of the global mode field
//   lane_mask_byte- byte-enable pattern of one byte lane for a given select
package debug_probe_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [1:0] {
        MODE_LANE = 2'd0,
        MODE_SRC  = 2'd1,
        MODE_MASK = 2'd2,
        MODE_SWAP = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_LIVE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    // Byte `lane` of the lane-marker word for select `sel`: all ones when the
    // select maps onto that lane (select wraps modulo the number of lanes).
    function automatic logic [7:0] lane_mask_byte(input int sel, input int lane, input int lanes);
        return ((sel % lanes) == lane) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/debug_probe_mux_if.sv
// debug_probe_mux_if: probe-mux signal bundle.
//   cfg_sel/cfg_mode - board-switch configuration (asynchronous to clk)
//   src_data         - packed probe sources, source k at [k*DATA_W +: DATA_W]
//   arm/trig/release_req - freeze control
//   ch_data          - registered channel outputs
//   frozen/armed     - controller state flags
//   cfg_upd          - pulse when a new configuration becomes active
// master drives the inputs of the mux, slave is the mux itself.
interface debug_probe_mux_if
    import debug_probe_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
) ();
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [NUM_CH*SEL_W-1:0]  cfg_sel;
    logic [MODE_W-1:0]        cfg_mode;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                     arm;
    logic                     trig;
    logic                     release_req;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     frozen;
    logic                     armed;
    logic                     cfg_upd;

    modport master (
        output cfg_sel, cfg_mode, src_data, arm, trig, release_req,
        input  ch_data, frozen, armed, cfg_upd
    );

    modport slave (
        input  cfg_sel, cfg_mode, src_data, arm, trig, release_req,
        output ch_data, frozen, armed, cfg_upd
    );
endinterface

// File: rtl/debug_probe_mux_cfg_debounce.sv
// cfg_debounce: two-flop synchroniser plus stability filter for a
// switch-driven configuration word.
//   clk, rst_n     - clock, synchronous active-low reset
//   i_cfg_async    - raw configuration, asynchronous to clk
//   o_cfg_active   - accepted configuration
//   o_cfg_upd      - one-cycle pulse in the cycle o_cfg_active changes
// A synchronised value must stay unchanged for DB_CYCLES cycles while
// differing from the active value before it is accepted.
module cfg_debounce
    import debug_probe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_cfg_async,
    output logic [WIDTH-1:0] o_cfg_active,
    output logic             o_cfg_upd
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_upd;
    logic             w_differs;
    logic             w_moving;

    assign w_differs = (r_sync2 != r_active);
    // r_sync2 is about to take a new value, so its stable run restarts.
    assign w_moving  = (r_sync1 != r_sync2);

    // Down-counter is reloaded whenever r_sync2 changes or matches the active
    // value, so reaching zero while still different means it has been stable
    // for DB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_upd    <= 1'b0;
        end else begin
            r_sync1 <= i_cfg_async;
            r_sync2 <= r_sync1;
            r_upd   <= 1'b0;
            if (w_differs && (r_cnt == '0)) begin
                r_active <= r_sync2;
                r_upd    <= 1'b1;
                r_cnt    <= CNT_LOAD;
            end else if (!w_differs || w_moving) begin
                r_cnt <= CNT_LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_cfg_active = r_active;
    assign o_cfg_upd    = r_upd;

endmodule

// File: rtl/debug_probe_mux.sv
// debug_probe_mux: switch-configured debug probe multiplexer with freeze.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - debug_probe_mux_if.slave (config, sources, freeze control,
//                channel outputs and status flags)
// Each channel shows a lane marker, a selected source, the masked source or
// the byte-swapped source. The freeze controller can hold all channels.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_LIVE   | channels follow sources, waiting for arm
//   ST_ARMED  | channels follow sources, trig freezes them
//   ST_FROZEN | channels hold the value captured at trig
module debug_probe_mux
    import debug_probe_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    debug_probe_mux_if.slave  bus
);
    localparam int SEL_W    = $clog2(NUM_SRC);
    localparam int LANES    = DATA_W / 8;
    localparam int SEL_BITS = NUM_CH * SEL_W;
    localparam int CFG_W    = MODE_W + SEL_BITS;

    logic [CFG_W-1:0]         w_cfg_active;
    logic                     w_cfg_upd;
    mode_e                    w_mode;
    logic [SEL_BITS-1:0]      w_sel_all;
    state_e                   r_state;
    state_e                   w_state_nxt;
    logic                     w_ch_en;
    logic [NUM_CH*DATA_W-1:0] w_ch_nxt;
    logic [NUM_CH*DATA_W-1:0] r_ch_data;

    cfg_debounce #(
        .WIDTH     (CFG_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_cfg_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_async  ({bus.cfg_mode, bus.cfg_sel}),
        .o_cfg_active (w_cfg_active),
        .o_cfg_upd    (w_cfg_upd)
    );

    assign w_mode    = mode_e'(w_cfg_active[CFG_W-1 -: MODE_W]);
    assign w_sel_all = w_cfg_active[SEL_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // release outranks arm and trig in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_en     = 1'b1;
        case (r_state)
            ST_LIVE: begin
                if (!bus.release_req && bus.arm) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.release_req) begin
                    w_state_nxt = ST_LIVE;
                end else if (bus.trig) begin
                    w_state_nxt = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                // Loading on the release edge makes the first live cycle
                // already show the current config and sources.
                w_ch_en = bus.release_req;
                if (bus.release_req) begin
                    w_state_nxt = ST_LIVE;
                end
            end
            default: begin
                w_state_nxt = ST_LIVE;
            end
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SEL_W-1:0]  w_sel;
        logic [DATA_W-1:0] w_src;
        logic [DATA_W-1:0] w_lane;
        logic [DATA_W-1:0] w_swap;
        logic [DATA_W-1:0] w_val;

        assign w_sel = w_sel_all[c*SEL_W +: SEL_W];
        assign w_src = bus.src_data[int'(w_sel)*DATA_W +: DATA_W];

        for (genvar b = 0; b < LANES; b++) begin : g_byte
            assign w_lane[b*8 +: 8] = lane_mask_byte(int'(w_sel), b, LANES);
            assign w_swap[b*8 +: 8] = w_src[(LANES-1-b)*8 +: 8];
        end

        always_comb begin
            w_val = w_lane;
            case (w_mode)
                MODE_LANE: w_val = w_lane;
                MODE_SRC:  w_val = w_src;
                MODE_MASK: w_val = w_src & w_lane;
                MODE_SWAP: w_val = w_swap;
                default:   w_val = w_lane;
            endcase
        end

        assign w_ch_nxt[c*DATA_W +: DATA_W] = w_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch_data <= '0;
        end else if (w_ch_en) begin
            r_ch_data <= w_ch_nxt;
        end
    end

    assign bus.ch_data = r_ch_data;
    assign bus.frozen  = (r_state == ST_FROZEN);
    assign bus.armed   = (r_state == ST_ARMED);
    assign bus.cfg_upd = w_cfg_upd;

endmodule

// File: doc/debug_probe_mux.md
DEBUG_PROBE_MUX -- requirements
Module: debug_probe_mux

Interface
REQ-001 Parameter NUM_CH, default 3: number of probe output channels.
REQ-002 Parameter NUM_SRC, default 4: number of selectable 32-bit sources; power of two, at least 2.
REQ-003 Parameter DATA_W, default 32: source and channel width; multiple of 8.
REQ-004 Parameter DB_CYCLES, default 16: cycles a config value must stay stable before it is accepted; at least 1.
REQ-005 Derived constants: SEL_W = $clog2(NUM_SRC); LANES = DATA_W/8.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 cfg_sel  in  NUM_CH*SEL_W  per-channel select from board switches; asynchronous to clk.
REQ-009 cfg_mode  in  2  global mode from board switches; asynchronous to clk.
REQ-010 src_data  in  NUM_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-011 arm  in  1  single-cycle request to arm the freeze trigger.
REQ-012 trig  in  1  freeze trigger event.
REQ-013 release  in  1  return-to-live request.
REQ-014 ch_data  out  NUM_CH*DATA_W  registered channel outputs.
REQ-015 frozen  out  1  high while in state FROZEN.
REQ-016 armed  out  1  high while in state ARMED.
REQ-017 cfg_upd  out  1  one-cycle pulse when a new config is accepted.

Function
REQ-018 cfg_sel and cfg_mode SHALL pass through a 2-flop synchroniser before any other use.
REQ-019 A synchronised config that differs from the active config SHALL become active only after it has stayed unchanged for DB_CYCLES consecutive cycles; any change restarts the count.
REQ-020 cfg_upd SHALL pulse in the same cycle the active config updates; ch_data SHALL reflect the new config one cycle later.
REQ-021 Mode 0 (LANE): channel c SHALL output 8'hFF in byte lane (sel_c mod LANES) and zeros in all other lanes.
REQ-022 Mode 1 (SRC): channel c SHALL output src_data source sel_c.
REQ-023 Mode 2 (MASK): channel c SHALL output source sel_c AND the mode-0 pattern for sel_c.
REQ-024 Mode 3 (SWAP): channel c SHALL output source sel_c with its byte order reversed.
REQ-025 The FSM SHALL have states LIVE, ARMED and FROZEN.
REQ-026 In LIVE and ARMED, ch_data SHALL update every cycle with a latency of 1 cycle from src_data.
REQ-027 In FROZEN, ch_data SHALL hold its value; config updates SHALL still be accepted but SHALL NOT change ch_data until exit.
REQ-028 Transitions:
- LIVE to ARMED on arm.
- ARMED to FROZEN on trig; the ch_data captured is the value computed from the src_data present in the trig cycle.
- ARMED or FROZEN to LIVE on release.
REQ-029 trig SHALL be ignored in LIVE and in FROZEN; arm SHALL be ignored in ARMED and in FROZEN.
REQ-030 release SHALL take priority over arm and trig when they are asserted in the same cycle.
REQ-031 On the first LIVE cycle after FROZEN, ch_data SHALL reflect the current active config and src_data.

Reset
REQ-032 When rst_n = 0 at a clock edge: ch_data = 0; frozen = 0; armed = 0; cfg_upd = 0; state = LIVE; active config = all zeros; debounce counter = 0; synchroniser flops = 0.
REQ-033 Reset asserted mid-freeze or mid-debounce SHALL abort the freeze or debounce with no residual effect.
REQ-034 In the first cycle after rst_n rises, ch_data SHALL reflect active config 0 (mode LANE, every sel = 0), giving 32'h000000FF per channel at the default parameters.

Structure
REQ-035 Package debug_probe_pkg SHALL hold:
- mode encodings LANE, SRC, MASK and SWAP;
- FSM state encodings;
- a function computing the byte-lane mask.
REQ-036 The synchroniser and debounce logic SHALL be one sub-module, cfg_debounce, parametrised by width and DB_CYCLES, instantiated once on the concatenation {cfg_mode, cfg_sel}.
REQ-037 Channel datapath SHALL be generated per channel; no other sub-modules.

Verification
REQ-038 Defaults, after reset, cfg_sel changed to {2'd3,2'd1,2'd2}, mode 0, held stable -> cfg_upd pulses 2+16 cycles after the change; next cycle ch_data = {32'hFF000000, 32'h0000FF00, 32'h00FF0000}.
REQ-039 cfg toggled every 10 cycles for 100 cycles with DB_CYCLES = 16 -> no cfg_upd pulse; ch_data unchanged.
REQ-040 Mode 2, sel0 = 1, src1 = 32'hA1B2C3D4 -> ch0 = 32'h0000C300; mode 3 -> ch0 = 32'hD4C3B2A1.
REQ-041 Mode 1, arm, trig while src0 = 32'h12345678, then src0 ramps -> ch0 holds 32'h12345678 and frozen = 1 until release; ch0 tracks src0 one cycle after release.
REQ-042 trig in LIVE -> no freeze; arm and release in the same cycle in LIVE -> armed stays 0; trig and release in the same cycle in ARMED -> returns to LIVE, frozen = 0.
REQ-043 rst_n low for one cycle while FROZEN -> next cycle: ch_data = 0, frozen = 0, armed = 0; cycle after that: ch_data = 32'hFF per channel.
